// File: rtl/phase_sequencer_pkg.sv
// Shared types for the intersection phase sequencer: traffic modes, FSM states,
// approach indices and the lane-bit / lane-count layout helpers.
package phase_sequencer_pkg;

    localparam int unsigned NUM_APPROACH = 4;
    localparam int unsigned LANE_W       = 8;

    typedef enum logic [1:0] {
        MODE_DAY   = 2'b00,
        MODE_NIGHT = 2'b01,
        MODE_PED   = 2'b10,
        MODE_EMG   = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        ST_START,
        ST_GREEN,
        ST_CLEAR,
        ST_PED,
        ST_EMG
    } state_t;

    typedef enum logic [1:0] {
        AP_N = 2'd0,
        AP_E = 2'd1,
        AP_S = 2'd2,
        AP_W = 2'd3
    } approach_t;

    // Lane bit 7..0 = N1,N2,E1,E2,S1,S2,W1,W2, so each approach owns a bit pair.
    function automatic approach_t lane_approach(input int unsigned bit_idx);
        return approach_t'(2'(3 - bit_idx / 2));
    endfunction

    function automatic logic [7:0] approach_mask(input approach_t ap);
        return 8'hC0 >> {ap, 1'b0};
    endfunction

    // The two lane counts of an approach form one contiguous 16-bit field.
    function automatic logic approach_busy(input approach_t ap, input logic [8*LANE_W-1:0] lanes);
        return |lanes[(3 - int'(ap)) * (2 * LANE_W) +: 2 * LANE_W];
    endfunction

    function automatic logic fits(input int unsigned value, input int unsigned width);
        return (value >> width) == 0;
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Countdown-timer link: the sequencer strobes loadEn/loadIn, the timer answers isZero.
interface phase_sequencer_if #(
    parameter int unsigned CNT_W = 7
);
    logic             loadEn;
    logic [CNT_W-1:0] loadIn;
    logic             isZero;

    modport master (output loadEn, output loadIn, input isZero);
    modport slave  (input loadEn, input loadIn, output isZero);
endinterface

// File: rtl/phase_sequencer_approach_picker.sv
// Combinational choice of the next approach to green and of the emergency target.
module approach_picker
    import phase_sequencer_pkg::*;
(
    input  approach_t   ptr,
    input  logic [63:0] lanes,
    input  logic        night,
    input  logic        emg_signal,
    input  logic [7:0]  emg_lane,
    output approach_t   next_ap,
    output approach_t   emg_target,
    output logic        emg_valid
);

    logic      found;
    logic [1:0] step;
    approach_t cand;

    // Night scan visits ptr+1..ptr+4; the last candidate is ptr itself, which
    // also covers the all-empty case by re-granting the current approach.
    always_comb begin
        found   = 1'b0;
        step    = 2'(ptr) + 2'd1;
        cand    = approach_t'(step);
        next_ap = cand;
        if (night) begin
            next_ap = ptr;
            for (int unsigned k = 1; k <= NUM_APPROACH; k++) begin
                step = 2'(ptr) + 2'(k);
                cand = approach_t'(step);
                if (!found && approach_busy(cand, lanes)) begin
                    next_ap = cand;
                    found   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        emg_target = AP_N;
        for (int unsigned i = 0; i < 8; i++) begin
            if (emg_lane[i]) begin
                emg_target = lane_approach(i);
            end
        end
        emg_valid = emg_signal & (|emg_lane);
    end

endmodule

// File: rtl/phase_sequencer.sv
// Intersection phase controller: one approach green at a time, emergency > pedestrian >
// rotation, with every state timed through the shared countdown timer.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W       = 7,
    parameter int unsigned DAY_GREEN   = 20,
    parameter int unsigned NIGHT_GREEN = 10,
    parameter int unsigned EMG_GREEN   = 30,
    parameter int unsigned PED_WALK    = 15,
    parameter int unsigned CLEAR_TIME  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dayNightSignal,
    input  logic                 pedSignal,
    input  logic                 emgSignal,
    input  logic [7:0]           emgLane,
    input  logic [63:0]          lanes,
    phase_sequencer_if.master    timer,
    output logic [1:0]           trafficMode,
    output logic [7:0]           dayTimeLightOutput,
    output logic [7:0]           walkingLightOutput
);

    if (!(fits(DAY_GREEN, CNT_W) && fits(NIGHT_GREEN, CNT_W) && fits(EMG_GREEN, CNT_W) &&
          fits(PED_WALK, CNT_W) && fits(CLEAR_TIME, CNT_W))) begin : g_bad_time
        $error("phase_sequencer: a time parameter is wider than CNT_W");
    end

    localparam logic [CNT_W-1:0] T_DAY   = CNT_W'(DAY_GREEN);
    localparam logic [CNT_W-1:0] T_NIGHT = CNT_W'(NIGHT_GREEN);
    localparam logic [CNT_W-1:0] T_EMG   = CNT_W'(EMG_GREEN);
    localparam logic [CNT_W-1:0] T_PED   = CNT_W'(PED_WALK);
    localparam logic [CNT_W-1:0] T_CLEAR = CNT_W'(CLEAR_TIME);

    state_t    state;
    state_t    go_state;
    approach_t ptr;
    approach_t emg_ap;
    approach_t go_ap;
    approach_t next_ap;
    approach_t emg_target;
    logic      emg_valid;
    logic      armed;
    logic      ped_pending;
    logic      expired;
    logic      go;

    logic [CNT_W-1:0] go_time;
    logic [1:0]       go_mode;
    logic [7:0]       go_cars;
    logic [7:0]       go_walk;

    approach_picker u_picker (
        .ptr        (ptr),
        .lanes      (lanes),
        .night      (~dayNightSignal),
        .emg_signal (emgSignal),
        .emg_lane   (emgLane),
        .next_ap    (next_ap),
        .emg_target (emg_target),
        .emg_valid  (emg_valid)
    );

    // isZero still reflects the previous load during the loadEn cycle.
    assign expired = armed & ~timer.loadEn & timer.isZero;

    // go marks a state entry (including an EMG reload); go_state/go_ap say which.
    always_comb begin
        go       = 1'b0;
        go_state = ST_CLEAR;
        go_ap    = ptr;
        case (state)
            ST_START: go = 1'b1;
            ST_CLEAR: begin
                if (expired) begin
                    go = 1'b1;
                    if (emg_valid) begin
                        go_state = ST_EMG;
                        go_ap    = emg_target;
                    end else if (ped_pending) begin
                        go_state = ST_PED;
                    end else begin
                        go_state = ST_GREEN;
                        go_ap    = next_ap;
                    end
                end
            end
            ST_GREEN: begin
                if (emg_valid) begin
                    go = 1'b1;
                    if (emg_target == ptr) begin
                        go_state = ST_EMG;
                        go_ap    = emg_target;
                    end
                end else if (expired) begin
                    go = 1'b1;
                end
            end
            ST_PED: go = emg_valid | expired;
            ST_EMG: begin
                if (emg_valid && emg_target != emg_ap) begin
                    go = 1'b1;
                end else if (expired) begin
                    go = 1'b1;
                    if (emg_valid) begin
                        go_state = ST_EMG;
                        go_ap    = emg_ap;
                    end
                end
            end
            default: go = 1'b1;
        endcase
    end

    // Clearance keeps the mode of the phase it follows.
    always_comb begin
        go_time = T_CLEAR;
        go_mode = trafficMode;
        go_cars = '0;
        go_walk = '0;
        case (go_state)
            ST_GREEN: begin
                go_time = dayNightSignal ? T_DAY : T_NIGHT;
                go_mode = dayNightSignal ? MODE_DAY : MODE_NIGHT;
                go_cars = approach_mask(go_ap);
            end
            ST_PED: begin
                go_time = T_PED;
                go_mode = MODE_PED;
                go_walk = '1;
            end
            ST_EMG: begin
                go_time = T_EMG;
                go_mode = MODE_EMG;
                go_cars = approach_mask(go_ap);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= ST_START;
            ptr                <= AP_W;
            emg_ap             <= AP_N;
            armed              <= 1'b0;
            ped_pending        <= 1'b0;
            timer.loadEn       <= 1'b0;
            timer.loadIn       <= '0;
            trafficMode        <= '0;
            dayTimeLightOutput <= '0;
            walkingLightOutput <= '0;
        end else begin
            timer.loadEn <= go;
            if (go) begin
                state              <= go_state;
                armed              <= 1'b0;
                timer.loadIn       <= go_time;
                trafficMode        <= go_mode;
                dayTimeLightOutput <= go_cars;
                walkingLightOutput <= go_walk;
                if (go_state == ST_GREEN || go_state == ST_EMG) begin
                    ptr <= go_ap;
                end
                if (go_state == ST_EMG) begin
                    emg_ap <= go_ap;
                end
            end else if (timer.loadEn) begin
                armed <= 1'b1;
            end
            ped_pending <= (go && go_state == ST_PED) ? pedSignal : (ped_pending | pedSignal);
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: behavioural countdown timer plus a scoreboard of
// expected state entries, compared on every loadEn strobe.
module tb_phase_sequencer;

    // A state loaded with time T lasts T+2 cycles: load cycle, T countdown cycles, expiry cycle.
    localparam int unsigned D_CLEAR = 3 + 2;
    localparam int unsigned D_DAY   = 20 + 2;
    localparam int unsigned D_NIGHT = 10 + 2;
    localparam int unsigned D_PED   = 15 + 2;
    localparam int unsigned D_EMG   = 30 + 2;

    typedef struct {
        string       tag;
        logic [6:0]  load_in;
        logic [1:0]  mode;
        logic [7:0]  cars;
        logic [7:0]  walk;
        int unsigned dwell;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        day_night;
    logic        ped;
    logic        emg;
    logic [7:0]  emg_lane;
    logic [63:0] lanes;
    logic [1:0]  mode;
    logic [7:0]  cars;
    logic [7:0]  walk;

    logic [6:0]  cnt    = '0;
    logic        zero_q = 1'b1;

    exp_t        sb[$];
    exp_t        cur;
    logic [1:0]  last_mode;
    int unsigned since_load;
    int          total = 0;
    int          bad   = 0;

    phase_sequencer_if #(.CNT_W(7)) tif ();

    phase_sequencer #(
        .CNT_W       (7),
        .DAY_GREEN   (20),
        .NIGHT_GREEN (10),
        .EMG_GREEN   (30),
        .PED_WALK    (15),
        .CLEAR_TIME  (3)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .dayNightSignal     (day_night),
        .pedSignal          (ped),
        .emgSignal          (emg),
        .emgLane            (emg_lane),
        .lanes              (lanes),
        .timer              (tif),
        .trafficMode        (mode),
        .dayTimeLightOutput (cars),
        .walkingLightOutput (walk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign tif.isZero = zero_q;
    always @(posedge clk) begin
        if (tif.loadEn) begin
            cnt    <= tif.loadIn;
            zero_q <= (tif.loadIn == 7'd0);
        end else if (cnt != 7'd0) begin
            cnt    <= cnt - 7'd1;
            zero_q <= (cnt == 7'd1);
        end else begin
            zero_q <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            since_load = 0;
        end else begin
            since_load++;
            if (tif.loadEn) begin
                if (sb.size() == 0) begin
                    check("spurious_load", 32'(tif.loadIn), 32'hFFFF);
                end else begin
                    cur = sb.pop_front();
                    check({cur.tag, ".loadIn"}, 32'(tif.loadIn), 32'(cur.load_in));
                    check({cur.tag, ".mode"}, 32'(mode), 32'(cur.mode));
                    check({cur.tag, ".cars"}, 32'(cars), 32'(cur.cars));
                    check({cur.tag, ".walk"}, 32'(walk), 32'(cur.walk));
                    if (cur.dwell != 0) begin
                        check({cur.tag, ".prev_dwell"}, since_load, cur.dwell);
                    end
                end
                since_load = 0;
            end
        end
    end

    task automatic push_entry(input string tag, input logic [6:0] ld, input logic [1:0] md,
                              input logic [7:0] cr, input logic [7:0] wk, input int unsigned dw);
        exp_t e;
        e.tag = tag; e.load_in = ld; e.mode = md; e.cars = cr; e.walk = wk; e.dwell = dw;
        sb.push_back(e);
        last_mode = md;
    endtask

    task automatic push_clear(input string tag, input int unsigned dw);
        push_entry(tag, 7'd3, last_mode, 8'h00, 8'h00, dw);
    endtask

    task automatic push_green(input string tag, input logic [7:0] cr, input logic is_day, input int unsigned dw);
        push_entry(tag, is_day ? 7'd20 : 7'd10, is_day ? 2'b00 : 2'b01, cr, 8'h00, dw);
    endtask

    task automatic push_ped(input string tag, input int unsigned dw);
        push_entry(tag, 7'd15, 2'b10, 8'h00, 8'hFF, dw);
    endtask

    task automatic push_emg(input string tag, input logic [7:0] cr, input int unsigned dw);
        push_entry(tag, 7'd30, 2'b11, cr, 8'h00, dw);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 600) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, ".drain"}, sb.size(), 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".loadEn"}, 32'(tif.loadEn), 0);
        check({tag, ".loadIn"}, 32'(tif.loadIn), 0);
        check({tag, ".mode"}, 32'(mode), 0);
        check({tag, ".cars"}, 32'(cars), 0);
        check({tag, ".walk"}, 32'(walk), 0);
    endtask

    task automatic release_rst();
        sb.delete();
        last_mode = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic restart();
        rst = 1'b1;
        release_rst();
    endtask

    task automatic pulse_ped();
        ped = 1'b1;
        @(negedge clk);
        #1;
        ped = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; day_night = 1'b1; ped = 1'b0; emg = 1'b0; emg_lane = 8'h00; lanes = 64'h0;
        last_mode = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");

        // Day rotation ignores empty lanes.
        release_rst();
        push_clear("s1.clr0", 0);
        push_green("s1.gN", 8'hC0, 1'b1, D_CLEAR);
        push_clear("s1.clr1", D_DAY);
        push_green("s1.gE", 8'h30, 1'b1, D_CLEAR);
        push_clear("s1.clr2", D_DAY);
        push_green("s1.gS", 8'h0C, 1'b1, D_CLEAR);
        push_clear("s1.clr3", D_DAY);
        push_green("s1.gW", 8'h03, 1'b1, D_CLEAR);
        push_clear("s1.clr4", D_DAY);
        push_green("s1.gN2", 8'hC0, 1'b1, D_CLEAR);
        wait_drain("s1");

        day_night = 1'b0;
        lanes     = 64'h00000000_07000000;
        restart();
        push_clear("s2.clr0", 0);
        push_green("s2.gS", 8'h0C, 1'b0, D_CLEAR);
        push_clear("s2.clr1", D_NIGHT);
        push_green("s2.gS2", 8'h0C, 1'b0, D_CLEAR);
        wait_drain("s2");

        day_night = 1'b1;
        lanes     = 64'h11_22_33_44_55_66_77_88;
        restart();
        push_clear("s3.clr0", 0);
        push_green("s3.gN", 8'hC0, 1'b1, D_CLEAR);
        wait_drain("s3a");
        pulse_ped();
        push_clear("s3.clr1", D_DAY);
        push_ped("s3.ped", D_CLEAR);
        push_clear("s3.clr2", D_PED);
        push_green("s3.gE", 8'h30, 1'b1, D_CLEAR);
        wait_drain("s3b");

        restart();
        push_clear("s4.clr0", 0);
        push_green("s4.gN", 8'hC0, 1'b1, D_CLEAR);
        wait_drain("s4a");
        emg = 1'b1; emg_lane = 8'h08;
        push_clear("s4.abort", 1);
        push_emg("s4.emg1", 8'h0C, D_CLEAR);
        push_emg("s4.emg2", 8'h0C, D_EMG);
        push_emg("s4.emg3", 8'h0C, D_EMG);
        wait_drain("s4b");
        emg = 1'b0; emg_lane = 8'h00;
        push_clear("s4.clr1", D_EMG);
        push_green("s4.gW", 8'h03, 1'b1, D_CLEAR);
        wait_drain("s4c");

        emg = 1'b1; emg_lane = 8'h00;
        restart();
        push_clear("s5.clr0", 0);
        push_green("s5.gN", 8'hC0, 1'b1, D_CLEAR);
        push_clear("s5.clr1", D_DAY);
        push_green("s5.gE", 8'h30, 1'b1, D_CLEAR);
        wait_drain("s5a");
        emg = 1'b0;

        restart();
        push_clear("s5b.clr0", 0);
        push_green("s5b.gN", 8'hC0, 1'b1, D_CLEAR);
        wait_drain("s5b");
        emg = 1'b1; emg_lane = 8'h40;
        push_emg("s5b.emgN", 8'hC0, 1);
        wait_drain("s5c");
        emg_lane = 8'h05;
        push_clear("s5b.retarget", 1);
        push_emg("s5b.emgS", 8'h0C, D_CLEAR);
        wait_drain("s5d");
        emg = 1'b0; emg_lane = 8'h00;

        restart();
        push_clear("s6.clr0", 0);
        push_green("s6.gN", 8'hC0, 1'b1, D_CLEAR);
        wait_drain("s6a");
        pulse_ped();
        push_clear("s6.clr1", D_DAY);
        push_ped("s6.ped", D_CLEAR);
        wait_drain("s6b");
        pulse_ped();
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle("s6.async");
        release_rst();
        push_clear("s6.clr2", 0);
        push_green("s6.gN2", 8'hC0, 1'b1, D_CLEAR);
        wait_drain("s6c");

        rst = 1'b1;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
